// File: rtl/loopback_regs_pkg.sv
// Register map constants, CTRL bit positions and the read FSM state type
// shared by the loopback register slave and its testbench.
package loopback_regs_pkg;

    localparam logic [2:0] REG_ID        = 3'd0;
    localparam logic [2:0] REG_CTRL      = 3'd1;
    localparam logic [2:0] REG_STATUS    = 3'd2;
    localparam logic [2:0] REG_MSG_COUNT = 3'd3;
    localparam logic [2:0] REG_SCRATCH   = 3'd4;
    localparam int         REG_LAST      = 4;

    localparam logic [31:0] ID_VALUE      = 32'h4C50_0001;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_MODE_MSB   = 2;
    localparam int CTRL_CLR_BIT    = 31;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PEND,
        RD_RESP
    } read_fsm_e;

endpackage

// File: rtl/loopback_rd_pipe.sv
// Fixed-depth valid/data shift pipe that delays captured read data to the
// Avalon response; the asynchronous reset doubles as the pipeline flush.
module loopback_rd_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    // Data is zeroed in empty slots so readdata stays 0 outside a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/loopback_reg_slave.sv
// Avalon-MM register bank for the loopback datapath: ID, CTRL, W1C STATUS,
// saturating MSG_COUNT and SCRATCH, with a single outstanding fixed-latency read.
module loopback_reg_slave #(
    parameter int ADDR_BASE    = 0,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    input  logic                msg_enter,
    input  logic [3:0]          evt_err,
    output logic                ctrl_enable,
    output logic [1:0]          ctrl_mode
);

    import loopback_regs_pkg::*;

    logic [ADDR_W-1:0] offset;
    logic              mapped;
    logic              wrAccept, rdAccept;
    logic              wrCtrl, wrStatus, wrScratch, msgClear;
    logic [DATA_W-1:0] beMask, wrMasked, rdData;

    logic [2:0]        ctrl_q, ctrl_d;
    logic [3:0]        status_q, status_d;
    logic [DATA_W-1:0] msgCount_q, msgCount_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;

    read_fsm_e         state_q;
    logic [2:0]        cnt_q;
    logic              wait_q;

    assign offset   = avs_address - ADDR_W'(ADDR_BASE);
    assign mapped   = (avs_address >= ADDR_W'(ADDR_BASE)) && (offset <= ADDR_W'(REG_LAST));
    assign wrAccept = avs_write && !wait_q;
    // A simultaneous read and write is a protocol error; the read is dropped.
    assign rdAccept = avs_read && !avs_write && !wait_q;

    assign wrCtrl    = wrAccept && mapped && (offset[2:0] == REG_CTRL);
    assign wrStatus  = wrAccept && mapped && (offset[2:0] == REG_STATUS);
    assign wrScratch = wrAccept && mapped && (offset[2:0] == REG_SCRATCH);

    always_comb begin
        beMask = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            beMask[i*8 +: 8] = {8{avs_byteenable[i]}};
        end
    end

    assign wrMasked = avs_writedata & beMask;
    assign msgClear = wrCtrl && wrMasked[CTRL_CLR_BIT];

    // Event sets are applied after the W1C clear so a same-cycle event wins;
    // likewise a message arriving with a count clear leaves the count at 1.
    always_comb begin
        ctrl_d     = ctrl_q;
        status_d   = status_q;
        msgCount_d = msgCount_q;
        scratch_d  = scratch_q;
        if (wrCtrl) begin
            ctrl_d = (ctrl_q & ~beMask[2:0]) | wrMasked[2:0];
        end
        if (wrStatus) begin
            status_d = status_q & ~wrMasked[3:0];
        end
        status_d = status_d | evt_err;
        if (msgClear) begin
            msgCount_d = msg_enter ? DATA_W'(1) : '0;
        end else if (msg_enter && (msgCount_q != '1)) begin
            msgCount_d = msgCount_q + DATA_W'(1);
        end
        if (wrScratch) begin
            scratch_d = (scratch_q & ~beMask) | wrMasked;
        end
    end

    always_comb begin
        rdData = DATA_W'(UNMAPPED_DATA);
        if (mapped) begin
            case (offset[2:0])
                REG_ID:        rdData = DATA_W'(ID_VALUE);
                REG_CTRL:      rdData = DATA_W'(ctrl_q);
                REG_STATUS:    rdData = DATA_W'(status_q);
                REG_MSG_COUNT: rdData = msgCount_q;
                REG_SCRATCH:   rdData = scratch_q;
                default:       rdData = DATA_W'(UNMAPPED_DATA);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            status_q   <= '0;
            msgCount_q <= '0;
            scratch_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            msgCount_q <= msgCount_d;
            scratch_q  <= scratch_d;
        end
    end

    // waitrequest is held from the cycle after accept through the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (rdAccept) begin
                        wait_q <= 1'b1;
                        if (READ_LATENCY == 1) begin
                            state_q <= RD_RESP;
                        end else begin
                            state_q <= RD_PEND;
                            cnt_q   <= 3'(READ_LATENCY - 1);
                        end
                    end
                end
                RD_PEND: begin
                    if (cnt_q == 3'd1) begin
                        state_q <= RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RD_RESP: begin
                    state_q <= RD_IDLE;
                    wait_q  <= 1'b0;
                end
                default: begin
                    state_q <= RD_IDLE;
                    wait_q  <= 1'b0;
                end
            endcase
        end
    end

    loopback_rd_pipe #(
        .DEPTH  (READ_LATENCY),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rdAccept),
        .data_i  (rdData),
        .valid_o (avs_readdatavalid),
        .data_o  (avs_readdata)
    );

    assign avs_waitrequest = wait_q;
    assign ctrl_enable     = ctrl_q[CTRL_ENABLE_BIT];
    assign ctrl_mode       = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

endmodule

// File: tb/tb_loopback_reg_slave.sv
// Scoreboard bench for loopback_reg_slave: reads push expected data and issue
// cycle into a queue, and a negedge monitor checks each readdatavalid against it.
module tb_loopback_reg_slave;

    localparam int ADDR_BASE = 8;
    localparam int RD_LAT    = 2;

    logic        clk;
    logic        rst;
    logic [15:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        msg_enter;
    logic [3:0]  evt_err;
    logic        ctrl_enable;
    logic [1:0]  ctrl_mode;

    typedef struct {
        logic [31:0] data;
        int          issueCycle;
    } expect_t;

    expect_t expQ[$];
    expect_t monEntry;
    int      compared   = 0;
    int      mismatched = 0;
    int      cycleCount = 0;

    loopback_reg_slave #(
        .ADDR_BASE    (ADDR_BASE),
        .DATA_W       (32),
        .ADDR_W       (16),
        .READ_LATENCY (RD_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .msg_enter         (msg_enter),
        .evt_err           (evt_err),
        .ctrl_enable       (ctrl_enable),
        .ctrl_mode         (ctrl_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Response monitor: every readdatavalid must match the oldest pending read.
    always @(negedge clk) begin
        if (!rst && avs_readdatavalid) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rdv: got readdata %h expected no response", avs_readdata);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("rd_data", avs_readdata, monEntry.data);
                checkOutput("rd_latency", 32'(cycleCount - monEntry.issueCycle), 32'(RD_LAT));
            end
        end
    end

    // Drives one bus cycle (plus optional same-cycle datapath events) once waitrequest is low.
    task automatic applyStimulus(input bit isWrite, input bit isRead, input logic [15:0] addr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 input logic [31:0] expData, input logic msg, input logic [3:0] err);
        int waited = 0;
        @(negedge clk);
        while (avs_waitrequest && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (avs_waitrequest) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitrequest_timeout: got 1 expected 0 within 50 cycles");
            return;
        end
        avs_address    = addr;
        avs_write      = isWrite;
        avs_read       = isRead;
        avs_writedata  = data;
        avs_byteenable = be;
        msg_enter      = msg;
        evt_err        = err;
        if (isRead && !isWrite) expQ.push_back('{data: expData, issueCycle: cycleCount});
        @(negedge clk);
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        msg_enter      = 1'b0;
        evt_err        = '0;
        if (isRead && !isWrite) checkOutput("waitreq_after_rd", 32'(avs_waitrequest), 32'd1);
    endtask

    task automatic wrReg(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        applyStimulus(1'b1, 1'b0, addr, data, be, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic rdReg(input logic [15:0] addr, input logic [31:0] expData);
        applyStimulus(1'b0, 1'b1, addr, 32'h0, 4'h0, expData, 1'b0, 4'h0);
    endtask

    task automatic pulseEvents(input logic msg, input logic [3:0] err);
        @(negedge clk);
        msg_enter = msg;
        evt_err   = err;
        @(negedge clk);
        msg_enter = 1'b0;
        evt_err   = '0;
    endtask

    logic [31:0] resetExp [5];
    int          drainWait;

    initial begin
        rst            = 1'b1;
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        msg_enter      = 1'b0;
        evt_err        = '0;
        resetExp       = '{32'h4C50_0001, 32'h0, 32'h0, 32'h0, 32'h0};
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        checkOutput("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        checkOutput("rst_readdata", avs_readdata, 32'h0);
        checkOutput("rst_ctrl_out", {29'h0, ctrl_mode, ctrl_enable}, 32'h0);

        for (int i = 0; i < 5; i++) rdReg(16'(ADDR_BASE + i), resetExp[i]);

        wrReg(16'(ADDR_BASE + 4), 32'hA5A5_A5A5, 4'b0101);
        rdReg(16'(ADDR_BASE + 4), 32'h00A5_00A5);

        for (int i = 0; i < 5; i++) pulseEvents(1'b1, 4'h0);
        rdReg(16'(ADDR_BASE + 3), 32'd5);
        applyStimulus(1'b1, 1'b0, 16'(ADDR_BASE + 1), 32'h8000_0000, 4'hF, 32'h0, 1'b1, 4'h0);
        rdReg(16'(ADDR_BASE + 3), 32'd1);
        rdReg(16'(ADDR_BASE + 1), 32'h0);

        wrReg(16'(ADDR_BASE + 1), 32'h0000_0005, 4'hF);
        checkOutput("ctrl_out_5", {29'h0, ctrl_mode, ctrl_enable}, 32'h5);
        wrReg(16'(ADDR_BASE + 1), 32'h0000_00FE, 4'b0001);
        checkOutput("ctrl_out_6", {29'h0, ctrl_mode, ctrl_enable}, 32'h6);
        rdReg(16'(ADDR_BASE + 1), 32'h6);

        pulseEvents(1'b0, 4'b0110);
        wrReg(16'(ADDR_BASE + 2), 32'h2, 4'hF);
        rdReg(16'(ADDR_BASE + 2), 32'h4);
        applyStimulus(1'b1, 1'b0, 16'(ADDR_BASE + 2), 32'h4, 4'hF, 32'h0, 1'b0, 4'b0100);
        rdReg(16'(ADDR_BASE + 2), 32'h4);
        wrReg(16'(ADDR_BASE + 2), 32'h4, 4'hF);
        rdReg(16'(ADDR_BASE + 2), 32'h0);

        rdReg(16'(ADDR_BASE + 7), 32'hDEAD_BEEF);
        rdReg(16'(ADDR_BASE - 1), 32'hDEAD_BEEF);
        wrReg(16'(ADDR_BASE + 7), 32'hFFFF_FFFF, 4'hF);
        wrReg(16'(ADDR_BASE - 1), 32'hFFFF_FFFF, 4'hF);
        rdReg(16'(ADDR_BASE + 1), 32'h6);
        rdReg(16'(ADDR_BASE + 2), 32'h0);
        rdReg(16'(ADDR_BASE + 3), 32'd1);
        rdReg(16'(ADDR_BASE + 4), 32'h00A5_00A5);

        applyStimulus(1'b1, 1'b1, 16'(ADDR_BASE + 4), 32'h1234_5678, 4'hF, 32'h0, 1'b0, 4'h0);
        rdReg(16'(ADDR_BASE + 4), 32'h1234_5678);

        @(negedge clk);
        while (avs_waitrequest) @(negedge clk);
        avs_address = 16'(ADDR_BASE);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        checkOutput("pend_waitreq", 32'(avs_waitrequest), 32'd1);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post_rst_rdv", 32'(avs_readdatavalid), 32'd0);
            checkOutput("post_rst_waitreq", 32'(avs_waitrequest), 32'd0);
        end
        checkOutput("post_rst_readdata", avs_readdata, 32'h0);
        checkOutput("post_rst_ctrl_out", {29'h0, ctrl_mode, ctrl_enable}, 32'h0);
        rdReg(16'(ADDR_BASE + 4), 32'h0);
        rdReg(16'(ADDR_BASE + 1), 32'h0);

        drainWait = 0;
        while (expQ.size() > 0 && drainWait < 20) begin
            @(negedge clk);
            drainWait++;
        end
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
